eq_band_regs: RTL and testbench

Parametrised memory-mapped register bank for the equalizer band display, generalising the fixed 12-dial peripheral to N bands of configurable width. Pending levels are written by the HPS over the Avalon-MM bus. They are committed atomically to an active bank at the next frame start, so the VGA renderer never draws a half-updated frame. Per-band peak-hold with timed decay is optional. A one-cycle-latency query port feeds the pixel pipeline.

---
 rtl/eq_band_regs_if.sv | 24 ++
 rtl/eq_band_regs.sv | 163 ++++++++++++++++
 tb/tb_eq_band_regs.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_band_regs_if.sv
// Avalon-MM slave bus for the equalizer band register bank.
// readdata is returned one cycle after chipselect&&read; the bus is never stalled.
// No waitrequest: every access completes in one cycle.
interface eq_band_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/eq_band_regs.sv
// Equalizer band registers: pending levels committed atomically at frame_start; optional peak-hold (EQ_PEAK_HOLD_EN).
// Latency: readdata, band_level and band_peak are all registered, one cycle after their request.
// Backpressure: none; bus accesses and frame_start are accepted every cycle.
module eq_band_regs #(
    parameter int NUM_BANDS   = 12,
    parameter int LEVEL_W     = 10,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int LEVEL_RESET = 412,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY_STEP  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    eq_band_regs_if.slave                bus,
    input  logic                         frame_start,
    input  logic [$clog2(NUM_BANDS)-1:0] band_sel,
    output logic [LEVEL_W-1:0]           band_level,
    output logic [LEVEL_W-1:0]           band_peak,
    output logic                         commit_pending
);

    localparam int IDX_W = $clog2(NUM_BANDS);
    localparam logic [LEVEL_W-1:0] LVL_RST = LEVEL_W'(LEVEL_RESET);

    logic rst_meta_n;
    logic rst_n;

    logic [LEVEL_W-1:0] pending_q  [NUM_BANDS];
    logic [LEVEL_W-1:0] active_q   [NUM_BANDS];
    logic [LEVEL_W-1:0] level_post [NUM_BANDS];
    logic [7:0]         frame_cnt_q;

    logic               wr_en;
    logic               rd_en;
    logic               addr_is_level;
    logic               addr_is_ctrl;
    logic               addr_is_status;
    logic [IDX_W-1:0]   addr_idx;
    logic               arm;
    logic               commit;
    logic               sel_ok;
    logic [LEVEL_W-1:0] wr_level;
    logic [DATA_W-1:0]  status_word;
    logic [DATA_W-1:0]  rd_mux;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_n <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_n      <= rst_meta_n;
        end
    end

    always_comb begin
        wr_en          = bus.chipselect && bus.write;
        rd_en          = bus.chipselect && bus.read;
        addr_idx       = bus.address[IDX_W-1:0];
        addr_is_level  = int'(bus.address) < NUM_BANDS;
        addr_is_ctrl   = bus.address == ADDR_W'(NUM_BANDS);
        addr_is_status = bus.address == ADDR_W'(NUM_BANDS + 1);
        arm            = wr_en && addr_is_ctrl && bus.writedata[0];
        commit         = frame_start && commit_pending;
        sel_ok         = int'(band_sel) < NUM_BANDS;
        // Any bit set above the level field saturates to full scale.
        if ((bus.writedata >> LEVEL_W) != '0) wr_level = '1;
        else                                  wr_level = bus.writedata[LEVEL_W-1:0];
    end

    always_comb begin
        status_word       = '0;
        status_word[0]    = commit_pending;
        status_word[15:8] = frame_cnt_q;
        rd_mux            = '0;
        if (addr_is_level)       rd_mux = DATA_W'(pending_q[addr_idx]);
        else if (addr_is_status) rd_mux = status_word;
    end

    // Level seen by this frame's peak tracker: the committed value if a commit fires now.
    always_comb begin
        for (int i = 0; i < NUM_BANDS; i++)
            level_post[i] = commit ? pending_q[i] : active_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) pending_q[i] <= LVL_RST;
        end else if (wr_en && addr_is_level) begin
            pending_q[addr_idx] <= wr_level;
        end
    end

    // Commit reads pending_q before this edge's write lands, so a coincident write waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) active_q[i] <= LVL_RST;
        end else if (commit) begin
            for (int i = 0; i < NUM_BANDS; i++) active_q[i] <= pending_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            frame_cnt_q    <= 8'd0;
            bus.readdata   <= '0;
        end else begin
            if (arm)         commit_pending <= 1'b1;
            else if (commit) commit_pending <= 1'b0;
            if (frame_start) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (rd_en)       bus.readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) band_level <= '0;
        else        band_level <= sel_ok ? active_q[band_sel] : '0;
    end

`ifdef EQ_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 2);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [LEVEL_W:0]   DSTEP_W   = (LEVEL_W + 1)'(DECAY_STEP);
    localparam logic [LEVEL_W-1:0] DSTEP_L   = DSTEP_W[LEVEL_W-1:0];

    logic [LEVEL_W-1:0] peak_q [NUM_BANDS];
    logic [HOLD_W-1:0]  hold_q [NUM_BANDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                peak_q[i] <= LVL_RST;
                hold_q[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (level_post[i] >= peak_q[i]) begin
                    peak_q[i] <= level_post[i];
                    hold_q[i] <= HOLD_INIT;
                end else if (hold_q[i] != '0) begin
                    hold_q[i] <= hold_q[i] - HOLD_W'(1);
                end else if ({1'b0, peak_q[i] - level_post[i]} > DSTEP_W) begin
                    peak_q[i] <= peak_q[i] - DSTEP_L;
                end else begin
                    // Decay would cross the live level: clamp onto it.
                    peak_q[i] <= level_post[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) band_peak <= '0;
        else        band_peak <= sel_ok ? peak_q[band_sel] : '0;
    end
`else
    assign band_peak = band_level;
`endif

endmodule

// File: tb/tb_eq_band_regs.sv
// Directed self-checking bench for eq_band_regs (default parameters).
// Peak expectations follow the EQ_PEAK_HOLD_EN build setting.
module tb_eq_band_regs;

    localparam int NB = 12;
    localparam int LW = 10;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic [3:0]    band_sel;
    logic [LW-1:0] band_level;
    logic [LW-1:0] band_peak;
    logic          commit_pending;

    int checks = 0;
    int errors = 0;
    int nframes = 0;

    logic [DW-1:0] rd;
    logic [LW-1:0] lvl;
    logic [LW-1:0] pk;
    logic [DW-1:0] exp_status;

    always #10 clk = ~clk;

    eq_band_regs_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    eq_band_regs #(
        .NUM_BANDS(NB), .LEVEL_W(LW), .DATA_W(DW), .ADDR_W(AW),
        .LEVEL_RESET(412), .HOLD_FRAMES(30), .DECAY_STEP(8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .frame_start    (frame_start),
        .band_sel       (band_sel),
        .band_level     (band_level),
        .band_peak      (band_peak),
        .commit_pending (commit_pending)
    );

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        nframes++;
    endtask

    task automatic query(input logic [3:0] sel, output logic [LW-1:0] l, output logic [LW-1:0] p);
        @(negedge clk); band_sel = sel;
        @(negedge clk);
        l = band_level; p = band_peak;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL rst_cp: got %0h want 0", commit_pending); end
        checks++; if (band_level !== '0) begin errors++; $display("FAIL rst_level: got %0d want 0", band_level); end
        checks++; if (band_peak !== '0) begin errors++; $display("FAIL rst_peak: got %0d want 0", band_peak); end
        checks++; if (bus.readdata !== '0) begin errors++; $display("FAIL rst_readdata: got %0h want 0", bus.readdata); end
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int a = 0; a < NB; a++) begin
            bus_read(AW'(a), rd);
            checks++; if (rd !== 16'd412) begin errors++; $display("FAIL rst_pending[%0d]: got %0d want 412", a, rd); end
        end
        query(4'd5, lvl, pk);
        checks++; if (lvl !== 10'd412) begin errors++; $display("FAIL rst_query5_level: got %0d want 412", lvl); end
        checks++; if (pk !== 10'd412) begin errors++; $display("FAIL rst_query5_peak: got %0d want 412", pk); end
        query(4'd12, lvl, pk);
        checks++; if (lvl !== '0 || pk !== '0) begin errors++; $display("FAIL query_oob: got %0d/%0d want 0/0", lvl, pk); end
        bus_read(4'd13, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_status: got %0h want 0000", rd); end
    endtask

    task automatic test_commit();
        bus_write(4'd3, 16'h0200);
        bus_read(4'd3, rd);
        checks++; if (rd !== 16'h0200) begin errors++; $display("FAIL pend3_read: got %0h want 0200", rd); end
        frame();
        query(4'd3, lvl, pk);
        checks++; if (lvl !== 10'd412) begin errors++; $display("FAIL no_commit_band3: got %0d want 412", lvl); end
        bus_write(4'd12, 16'h0000);
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL ctrl_zero: got %0h want 0", commit_pending); end
        bus_write(4'd12, 16'h0001);
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL ctrl_arm: got %0h want 1", commit_pending); end
        frame();
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL commit_clear: got %0h want 0", commit_pending); end
        query(4'd3, lvl, pk);
        checks++; if (lvl !== 10'd512) begin errors++; $display("FAIL commit_band3: got %0d want 512", lvl); end
        bus_read(4'd13, rd);
        checks++; if (rd !== 16'h0200) begin errors++; $display("FAIL status_frames2: got %0h want 0200", rd); end
    endtask

    task automatic test_saturate();
        bus_write(4'd0, 16'hFFFF);
        bus_read(4'd0, rd);
        checks++; if (rd !== 16'h03FF) begin errors++; $display("FAIL sat_ffff: got %0h want 03ff", rd); end
        repeat (3) @(negedge clk);
        checks++; if (bus.readdata !== 16'h03FF) begin errors++; $display("FAIL readdata_hold: got %0h want 03ff", bus.readdata); end
        bus_write(4'd0, 16'h0400);
        bus_read(4'd0, rd);
        checks++; if (rd !== 16'h03FF) begin errors++; $display("FAIL sat_0400: got %0h want 03ff", rd); end
        bus_write(4'd0, 16'h03FE);
        bus_read(4'd0, rd);
        checks++; if (rd !== 16'h03FE) begin errors++; $display("FAIL nosat_03fe: got %0h want 03fe", rd); end
        bus_write(4'd14, 16'h1234);
        bus_read(4'd14, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %0h want 0000", rd); end
        bus_read(4'd0, rd);
        checks++; if (rd !== 16'h03FE) begin errors++; $display("FAIL unmapped_nowrite: got %0h want 03fe", rd); end
        bus_read(4'd12, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ctrl_read: got %0h want 0000", rd); end
    endtask

    task automatic test_coincident_write();
        bus_write(4'd12, 16'h0001);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd1; bus.writedata = 16'd100;
        frame_start = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0; frame_start = 1'b0;
        nframes++;
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL coinc_cp: got %0h want 0", commit_pending); end
        query(4'd1, lvl, pk);
        checks++; if (lvl !== 10'd412) begin errors++; $display("FAIL coinc_band1_old: got %0d want 412", lvl); end
        query(4'd0, lvl, pk);
        checks++; if (lvl !== 10'h3FE) begin errors++; $display("FAIL coinc_band0: got %0h want 3fe", lvl); end
        bus_read(4'd1, rd);
        checks++; if (rd !== 16'd100) begin errors++; $display("FAIL coinc_pend1: got %0d want 100", rd); end
        bus_write(4'd12, 16'h0001);
        frame();
        query(4'd1, lvl, pk);
        checks++; if (lvl !== 10'd100) begin errors++; $display("FAIL coinc_band1_new: got %0d want 100", lvl); end
    endtask

    task automatic test_arm_coincident();
        bus_write(4'd4, 16'd7);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 4'd12; bus.writedata = 16'h0001;
        frame_start = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0; frame_start = 1'b0;
        nframes++;
        checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL armcoinc_cp: got %0h want 1", commit_pending); end
        query(4'd4, lvl, pk);
        checks++; if (lvl !== 10'd412) begin errors++; $display("FAIL armcoinc_band4_old: got %0d want 412", lvl); end
        frame();
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL armcoinc_cp_clear: got %0h want 0", commit_pending); end
        query(4'd4, lvl, pk);
        checks++; if (lvl !== 10'd7) begin errors++; $display("FAIL armcoinc_band4_new: got %0d want 7", lvl); end
    endtask

    task automatic test_peak();
        bus_write(4'd2, 16'd800);
        bus_write(4'd12, 16'h0001);
        frame();
        query(4'd2, lvl, pk);
        checks++; if (lvl !== 10'd800 || pk !== 10'd800) begin errors++; $display("FAIL peak_rise: got %0d/%0d want 800/800", lvl, pk); end
        bus_write(4'd2, 16'd100);
        bus_write(4'd12, 16'h0001);
        frame();
`ifdef EQ_PEAK_HOLD_EN
        repeat (29) frame();
        query(4'd2, lvl, pk);
        checks++; if (lvl !== 10'd100) begin errors++; $display("FAIL peak_level100: got %0d want 100", lvl); end
        checks++; if (pk !== 10'd800) begin errors++; $display("FAIL peak_hold_end: got %0d want 800", pk); end
        frame();
        query(4'd2, lvl, pk);
        checks++; if (pk !== 10'd792) begin errors++; $display("FAIL peak_decay1: got %0d want 792", pk); end
        frame();
        query(4'd2, lvl, pk);
        checks++; if (pk !== 10'd784) begin errors++; $display("FAIL peak_decay2: got %0d want 784", pk); end
        repeat (85) frame();
        query(4'd2, lvl, pk);
        checks++; if (pk !== 10'd104) begin errors++; $display("FAIL peak_decay87: got %0d want 104", pk); end
        frame();
        query(4'd2, lvl, pk);
        checks++; if (pk !== 10'd100) begin errors++; $display("FAIL peak_clamp: got %0d want 100", pk); end
        frame();
        query(4'd2, lvl, pk);
        checks++; if (pk !== 10'd100 || lvl !== 10'd100) begin errors++; $display("FAIL peak_floor: got %0d/%0d want 100/100", lvl, pk); end
`else
        query(4'd2, lvl, pk);
        checks++; if (lvl !== 10'd100 || pk !== 10'd100) begin errors++; $display("FAIL peak_track: got %0d/%0d want 100/100", lvl, pk); end
        query(4'd3, lvl, pk);
        checks++; if (lvl !== 10'd512 || pk !== 10'd512) begin errors++; $display("FAIL peak_track3: got %0d/%0d want 512/512", lvl, pk); end
`endif
    endtask

    task automatic test_reset_mid();
        bus_write(4'd12, 16'h0001);
        exp_status = DW'(((nframes % 256) << 8) | 1);
        bus_read(4'd13, rd);
        checks++; if (rd !== exp_status) begin errors++; $display("FAIL pre_rst_status: got %0h want %0h", rd, exp_status); end
        query(4'd3, lvl, pk);
        @(posedge clk);
        #5 reset_n = 1'b0;
        #1;
        checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL midrst_cp: got %0h want 0", commit_pending); end
        checks++; if (band_level !== '0 || band_peak !== '0) begin errors++; $display("FAIL midrst_query: got %0d/%0d want 0/0", band_level, band_peak); end
        checks++; if (bus.readdata !== '0) begin errors++; $display("FAIL midrst_readdata: got %0h want 0", bus.readdata); end
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        nframes = 0;
        bus_read(4'd13, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_status: got %0h want 0000", rd); end
        query(4'd3, lvl, pk);
        checks++; if (lvl !== 10'd412) begin errors++; $display("FAIL midrst_active3: got %0d want 412", lvl); end
        bus_read(4'd3, rd);
        checks++; if (rd !== 16'd412) begin errors++; $display("FAIL midrst_pend3: got %0d want 412", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        frame_start    = 1'b0;
        band_sel       = '0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        test_reset();
        test_commit();
        test_saturate();
        test_coincident_write();
        test_arm_coincident();
        test_peak();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
